ps2_poll_ctrl: RTL

- Sequencer that periodically polls the PS2 gamepad through a byte-level SPI master.
- Owns chip select, issues the 5-byte poll frame (0x01, 0x42, 0x00, 0x00, 0x00) and validates the reply.
- Publishes a debounced-per-frame 16-bit active-high key vector plus press/release event pulses.
- Sits between the SPI byte engine and the game-console key consumers (LED decode, CPU GPIO).

---
 rtl/ps2_poll_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_poll_ctrl.sv
// ps2_poll_ctrl: periodic PS2 gamepad poll sequencer over a byte-level SPI master.
// Sends 01 42 00 00 00, validates the reply and publishes key state and events.
module ps2_poll_ctrl #(
   parameter int POLL_CYCLES = 1000000,
   parameter int CS_SETUP    = 50,
   parameter int BYTE_GAP    = 25,
   parameter int TIMEOUT     = 5000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   output logic        spi_cs_n,
   output logic        spi_start,
   output logic [7:0]  spi_tx_byte,
   input  logic        spi_done,
   input  logic [7:0]  spi_rx_byte,
   output logic [15:0] ps2_key,
   output logic        key_valid,
   output logic [15:0] key_press,
   output logic [15:0] key_release,
   output logic        frame_err,
   output logic        link_ok
);

   localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
   localparam int CMAX_A = (TIMEOUT > CS_SETUP) ? TIMEOUT : CS_SETUP;
   localparam int CMAX = (CMAX_A > BYTE_GAP) ? CMAX_A : BYTE_GAP;
   localparam int CW = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CS_SETUP,
      S_SEND,
      S_WAIT,
      S_GAP,
      S_CHECK,
      S_ABORT
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   poll_q, poll_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [2:0]      idx_m1;
   logic [3:0][7:0] rx_q, rx_d;
   logic [7:0]      tx_byte_q, tx_byte_d;
   logic [15:0]     key_q, key_d;
   logic [15:0]     press_q, press_d;
   logic [15:0]     release_q, release_d;
   logic            key_valid_q, key_valid_d;
   logic            frame_err_q, frame_err_d;
   logic            link_ok_q, link_ok_d;
   logic            tick;
   logic            frame_ok;
   logic [15:0]     key_new;

   function automatic logic [7:0] poll_byte(input logic [2:0] i);
      logic [7:0] b;
      case (i)
         3'd0:    b = 8'h01;
         3'd1:    b = 8'h42;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Timer only runs while enabled; a wrap is the poll request.
   assign tick = enable && (poll_q == PW'(POLL_CYCLES - 1));

   always_comb begin
      poll_d = poll_q + PW'(1);
      if (!enable || tick) begin
         poll_d = '0;
      end
   end

   // rx_q[k] holds reply byte k+1; byte 0 carries no information.
   assign idx_m1   = idx_q - 3'd1;
   assign frame_ok = ((rx_q[0] == 8'h41) || (rx_q[0] == 8'h73))
                     && (rx_q[1] == 8'h5A);
   assign key_new  = ~{rx_q[3], rx_q[2]};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      rx_d        = rx_q;
      tx_byte_d   = tx_byte_q;
      key_d       = key_q;
      press_d     = '0;
      release_d   = '0;
      key_valid_d = 1'b0;
      frame_err_d = 1'b0;
      link_ok_d   = link_ok_q;
      case (state_q)
         S_IDLE: begin
            if (tick) begin
               state_d = S_CS_SETUP;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
         S_CS_SETUP: begin
            if (cnt_q == CW'(CS_SETUP - 1)) begin
               state_d   = S_SEND;
               idx_d     = '0;
               tx_byte_d = poll_byte(3'd0);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_SEND: begin
            state_d = S_WAIT;
            cnt_d   = '0;
         end
         S_WAIT: begin
            // A completion on the last allowed cycle still counts.
            if (spi_done) begin
               if (idx_q != 3'd0) begin
                  rx_d[idx_m1[1:0]] = spi_rx_byte;
               end
               cnt_d   = '0;
               state_d = (idx_q == 3'd4) ? S_CHECK : S_GAP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d = S_ABORT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_GAP: begin
            if (cnt_q == CW'(BYTE_GAP - 1)) begin
               state_d   = S_SEND;
               idx_d     = idx_q + 3'd1;
               tx_byte_d = poll_byte(idx_q + 3'd1);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_CHECK: begin
            state_d = S_IDLE;
            if (frame_ok) begin
               key_d       = key_new;
               press_d     = key_new & ~key_q;
               release_d   = ~key_new & key_q;
               key_valid_d = 1'b1;
               link_ok_d   = 1'b1;
            end else begin
               frame_err_d = 1'b1;
               link_ok_d   = 1'b0;
            end
         end
         S_ABORT: begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            link_ok_d   = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         poll_q      <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         rx_q        <= '0;
         tx_byte_q   <= '0;
         key_q       <= '0;
         press_q     <= '0;
         release_q   <= '0;
         key_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         link_ok_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         poll_q      <= poll_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         rx_q        <= rx_d;
         tx_byte_q   <= tx_byte_d;
         key_q       <= key_d;
         press_q     <= press_d;
         release_q   <= release_d;
         key_valid_q <= key_valid_d;
         frame_err_q <= frame_err_d;
         link_ok_q   <= link_ok_d;
      end
   end

   assign spi_cs_n    = !((state_q == S_CS_SETUP) || (state_q == S_SEND)
                          || (state_q == S_WAIT) || (state_q == S_GAP));
   assign spi_start   = (state_q == S_SEND);
   assign spi_tx_byte = tx_byte_q;
   assign ps2_key     = key_q;
   assign key_valid   = key_valid_q;
   assign key_press   = press_q;
   assign key_release = release_q;
   assign frame_err   = frame_err_q;
   assign link_ok     = link_ok_q;

endmodule
